// File: rtl/core_pkg.sv
// core_pkg -- shared definitions for the integer core: ALU operation codes,
// operand-0 select encoding, base opcode constants and the decoded
// instruction record carried by the decode pipeline register.
package core_pkg;

    localparam int CORE_XLEN = 32;

    // ALU operation codes, shared between the decoder and the ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0110,
        ALU_XOR  = 4'b1000,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_OR   = 4'b1100,
        ALU_AND  = 4'b1110
    } alu_op_t;

    // Operand-0 source select for the ALU.
    typedef enum logic [1:0] {
        IN0_RS1  = 2'd0,
        IN0_PC   = 2'd1,
        IN0_ZERO = 2'd2
    } in0_sel_t;

    // Base opcodes handled by this decoder.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values: base encoding and the SUB/SRA alternate encoding.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded fields as held in the decode/execute pipeline register.
    typedef struct packed {
        alu_op_t                alu_op;
        logic [CORE_XLEN-1:0]   imm;
        logic [4:0]             rs1_addr;
        logic [4:0]             rs2_addr;
        logic [4:0]             rd_addr;
        logic                   rd_we;
        in0_sel_t               in0_sel;
        logic                   in1_sel_imm;
        logic                   illegal;
    } dec_t;

    // Map funct3 plus the alternate-encoding bit to an ALU operation.
    // Callers only pass alt=1 for funct3 000 (SUB) and 101 (SRA).
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder -- purely combinational decode of OP, OP-IMM, LUI and AUIPC
// into ALU control, immediate and register fields. Anything else is flagged
// illegal with no register write, ADD and a zero immediate.
module instr_decoder
    import core_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  alu_op_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic [1:0]  in0_sel_o,
    output logic        in1_sel_imm_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i_type;
    logic [31:0] imm_shamt;
    logic [31:0] imm_u_type;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_shamt  = {27'b0, instr_i[24:20]};
    assign imm_u_type = {instr_i[31:12], 12'b0};

    alu_op_t     alu_op;
    in0_sel_t    in0_sel;
    logic        in1_sel_imm;
    logic [31:0] imm;
    logic        legal;

    // Opcode/funct decode; only legal branches touch the control fields.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        alu_op      = ALU_ADD;
        in0_sel     = IN0_RS1;
        in1_sel_imm = 1'b0;
        imm         = '0;
        legal       = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    alu_op = alu_from_funct3(funct3, 1'b0);
                    legal  = 1'b1;
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    alu_op = alu_from_funct3(funct3, 1'b1);
                    legal  = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) begin
                            alu_op      = ALU_SLL;
                            imm         = imm_shamt;
                            in1_sel_imm = 1'b1;
                            legal       = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                            alu_op      = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                            imm         = imm_shamt;
                            in1_sel_imm = 1'b1;
                            legal       = 1'b1;
                        end
                    end
                    default: begin
                        // ADDI has no SUB form: funct7 bits belong to the immediate here.
                        alu_op      = alu_from_funct3(funct3, 1'b0);
                        imm         = imm_i_type;
                        in1_sel_imm = 1'b1;
                        legal       = 1'b1;
                    end
                endcase
            end

            OPC_LUI: begin
                in0_sel     = IN0_ZERO;
                imm         = imm_u_type;
                in1_sel_imm = 1'b1;
                legal       = 1'b1;
            end

            OPC_AUIPC: begin
                in0_sel     = IN0_PC;
                imm         = imm_u_type;
                in1_sel_imm = 1'b1;
                legal       = 1'b1;
            end

            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign alu_op_o      = alu_op;
    assign imm_o         = imm;
    assign in0_sel_o     = in0_sel;
    assign in1_sel_imm_o = in1_sel_imm;
    assign illegal_o     = !legal;

    // Register fields pass through raw; writes to x0 are suppressed.
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign rd_addr_o  = instr_i[11:7];
    assign rd_we_o    = legal && (instr_i[11:7] != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// decode_stage -- decode pipeline stage: valid/ready handshake toward fetch
// and execute, one pipeline register of decoded fields, flush and reset.
// Optional feature macro DECODE_SKID_BUF_EN adds a one-entry skid buffer so
// that if_ready comes from state only (no combinational path from ex_ready).
// Without the macro, if_ready = !flush && (!ex_valid || ex_ready).
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [3:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_rd_we,
    output logic [1:0]      ex_in0_sel,
    output logic            ex_in1_sel_imm,
    output logic            ex_illegal
);

    // Output pipeline register.
    logic            valid_q, valid_d;
    dec_t            dec_q, dec_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Instruction presented to the decoder (incoming, or the skid entry).
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;
    dec_t            dec_w;

    logic accept;    // transfer from fetch this cycle
    logic out_free;  // output register may be overwritten at the next edge

    assign out_free = !valid_q || ex_ready;
    assign accept   = if_valid && if_ready;

    logic [3:0] dec_alu_op;
    logic [1:0] dec_in0_sel;

    instr_decoder u_instr_decoder (
        .instr_i       (src_instr),
        .alu_op_o      (dec_alu_op),
        .imm_o         (dec_w.imm),
        .rs1_addr_o    (dec_w.rs1_addr),
        .rs2_addr_o    (dec_w.rs2_addr),
        .rd_addr_o     (dec_w.rd_addr),
        .rd_we_o       (dec_w.rd_we),
        .in0_sel_o     (dec_in0_sel),
        .in1_sel_imm_o (dec_w.in1_sel_imm),
        .illegal_o     (dec_w.illegal)
    );

    assign dec_w.alu_op  = alu_op_t'(dec_alu_op);
    assign dec_w.in0_sel = in0_sel_t'(dec_in0_sel);

`ifdef DECODE_SKID_BUF_EN

    // One-entry skid buffer holding a raw instruction accepted while stalled.
    logic            skid_full_q, skid_full_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    // Ready depends only on skid occupancy (a flop), flush and reset.
    assign if_ready  = !rst && !flush && !skid_full_q;

    // The skid entry is older than anything arriving, so it is decoded first.
    assign src_instr = skid_full_q ? skid_instr_q : if_instr;
    assign src_pc    = skid_full_q ? skid_pc_q    : if_pc;

    // Next state: refill output from skid first, else from fetch; stalled transfers park in skid.
    always_comb begin
        valid_d      = valid_q;
        dec_d        = dec_q;
        pc_d         = pc_q;
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
        end else if (out_free) begin
            if (skid_full_q) begin
                valid_d     = 1'b1;
                dec_d       = dec_w;
                pc_d        = src_pc;
                skid_full_d = 1'b0;
            end else if (accept) begin
                valid_d = 1'b1;
                dec_d   = dec_w;
                pc_d    = src_pc;
            end else begin
                valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d  = 1'b1;
            skid_instr_d = if_instr;
            skid_pc_d    = if_pc;
        end
    end

    // Skid buffer state; reset empties it so a buffered instruction is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full_q  <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`else

    // Ready whenever the output register is empty or draining this cycle.
    assign if_ready  = !rst && !flush && out_free;

    assign src_instr = if_instr;
    assign src_pc    = if_pc;

    // Next state: load on transfer, clear on drain or flush, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        pc_d    = pc_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec_w;
            pc_d    = src_pc;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

`endif

    // Output pipeline register with asynchronous clear to the idle ADD/zero state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data fields are reset too, not just valid, because every ex_* output must read zero while rst is high.
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            valid_q <= valid_d;
            dec_q   <= dec_d;
            pc_q    <= pc_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_pc          = pc_q;
    assign ex_alu_op      = dec_q.alu_op;
    assign ex_imm         = dec_q.imm;
    assign ex_rs1_addr    = dec_q.rs1_addr;
    assign ex_rs2_addr    = dec_q.rs2_addr;
    assign ex_rd_addr     = dec_q.rd_addr;
    assign ex_rd_we       = dec_q.rd_we;
    assign ex_in0_sel     = dec_q.in0_sel;
    assign ex_in1_sel_imm = dec_q.in1_sel_imm;
    assign ex_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- self-checking bench for decode_stage: directed vectors,
// stall/flush/reset scenarios and randomized traffic checked against a
// transaction-level reference (mnemonic decode table + FIFO of accepted items).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1_addr;
    logic [4:0]  ex_rs2_addr;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;
    logic [1:0]  ex_in0_sel;
    logic        ex_in1_sel_imm;
    logic        ex_illegal;

    decode_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_alu_op      (ex_alu_op),
        .ex_imm         (ex_imm),
        .ex_rs1_addr    (ex_rs1_addr),
        .ex_rs2_addr    (ex_rs2_addr),
        .ex_rd_addr     (ex_rd_addr),
        .ex_rd_we       (ex_rd_we),
        .ex_in0_sel     (ex_in0_sel),
        .ex_in1_sel_imm (ex_in1_sel_imm),
        .ex_illegal     (ex_illegal)
    );

    always #5 clk = ~clk;

`ifdef DECODE_SKID_BUF_EN
    localparam int DEPTH = 2;  // output register + skid entry
`else
    localparam int DEPTH = 1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam bit [3:0] A_ADD = 4'd0,  A_SUB = 4'd1,  A_SLL = 4'd2,  A_SLT = 4'd4;
    localparam bit [3:0] A_SLTU = 4'd6, A_XOR = 4'd8,  A_SRL = 4'd10, A_SRA = 4'd11;
    localparam bit [3:0] A_OR = 4'd12,  A_AND = 4'd14;

    typedef struct {
        bit        legal;
        bit [3:0]  alu;
        bit [31:0] imm;
        bit        chk_imm;
        bit [1:0]  in0;
        bit        in1;
        bit        use_rs1;
        bit        use_rs2;
    } exp_t;

    typedef struct {
        bit [31:0] instr;
        bit [31:0] pc;
    } txn_t;

    txn_t sb[$];

    function automatic bit [3:0] mnemonic_alu(input bit [2:0] f3, input bit alt);
        case (f3)
            3'd0: return alt ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return alt ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic exp_t ref_decode(input bit [31:0] ins);
        exp_t     e;
        bit [6:0] opc;
        bit [6:0] f7;
        bit [2:0] f3;
        int       simm;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        simm = int'(ins[31:20]);
        if (ins[31]) simm = simm - 4096;
        e.legal = 0; e.alu = A_ADD; e.imm = 0; e.chk_imm = 1;
        e.in0 = 0; e.in1 = 0; e.use_rs1 = 0; e.use_rs2 = 0;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    e.legal = 1; e.alu = mnemonic_alu(f3, f7 == 7'h20);
                    e.chk_imm = 0; e.use_rs1 = 1; e.use_rs2 = 1;
                end
            end
            7'h13: begin
                if (f3 == 3'd1) begin
                    if (f7 == 7'h00) begin
                        e.legal = 1; e.alu = A_SLL; e.imm = 32'(ins[24:20]);
                    end
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h00 || f7 == 7'h20) begin
                        e.legal = 1; e.alu = mnemonic_alu(f3, f7 == 7'h20); e.imm = 32'(ins[24:20]);
                    end
                end else begin
                    e.legal = 1; e.alu = mnemonic_alu(f3, 1'b0); e.imm = 32'(simm);
                end
                if (e.legal) begin e.in1 = 1; e.use_rs1 = 1; end
            end
            7'h37: begin e.legal = 1; e.imm = ins & 32'hFFFF_F000; e.in0 = 2; e.in1 = 1; end
            7'h17: begin e.legal = 1; e.imm = ins & 32'hFFFF_F000; e.in0 = 1; e.in1 = 1; end
            default: e.legal = 0;
        endcase
        return e;
    endfunction

    task automatic compare_out(input txn_t t);
        exp_t e;
        e = ref_decode(t.instr);
        check("pc", ex_pc, t.pc);
        check("illegal", ex_illegal, !e.legal);
        check("alu_op", ex_alu_op, e.alu);
        check("rd_we", ex_rd_we, e.legal && t.instr[11:7] != 5'd0);
        if (e.chk_imm) check("imm", ex_imm, e.imm);
        if (e.legal) begin
            check("rd", ex_rd_addr, t.instr[11:7]);
            check("in0_sel", ex_in0_sel, e.in0);
            check("in1_sel_imm", ex_in1_sel_imm, e.in1);
        end
        if (e.use_rs1) check("rs1", ex_rs1_addr, t.instr[19:15]);
        if (e.use_rs2) check("rs2", ex_rs2_addr, t.instr[24:20]);
    endtask

    function automatic logic [95:0] out_vec();
        return {7'b0, ex_valid, ex_pc, ex_imm, ex_alu_op, ex_rs1_addr, ex_rs2_addr,
                ex_rd_addr, ex_rd_we, ex_in0_sel, ex_in1_sel_imm, ex_illegal};
    endfunction

    // ---------------- cycle driver ----------------
    logic s_accept;

    // Sample at negedge, check against the model, then advance the model past the posedge.
    task automatic step();
        logic s_fire, s_flush;
        @(negedge clk);
        s_accept = if_valid && if_ready;
        s_fire   = ex_valid && ex_ready;
        s_flush  = flush;
        check("ex_valid", ex_valid, sb.size() != 0);
`ifdef DECODE_SKID_BUF_EN
        check("if_ready", if_ready, !flush && sb.size() < DEPTH);
`else
        check("if_ready", if_ready, !flush && (sb.size() == 0 || ex_ready));
`endif
        if (s_fire) begin
            if (sb.size() == 0) check("unexpected_out", 1'b1, 1'b0);
            else compare_out(sb[0]);
        end
        @(posedge clk);
        #1;
        if (s_fire && sb.size() != 0) void'(sb.pop_front());
        if (s_flush) sb.delete();
        else if (s_accept) sb.push_back('{instr: if_instr, pc: if_pc});
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1'b1; if_instr = ins; if_pc = pc; ex_ready = 1'b1;
        step();
        check("send_accept", s_accept, 1'b1);
        if_valid = 1'b0;
    endtask

    task automatic drain();
        if_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 8 && (sb.size() != 0 || ex_valid); i++) step();
        check("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k, f;
        r = $urandom;
        k = $urandom_range(0, 9);
        f = $urandom_range(0, 3);
        if (k <= 5) begin
            r[6:0] = (k <= 2) ? 7'h33 : 7'h13;
            if (f <= 1) r[31:25] = 7'h00;
            else if (f == 2) r[31:25] = 7'h20;
        end else if (k == 6) r[6:0] = 7'h37;
        else if (k == 7) r[6:0] = 7'h17;
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [95:0] snap;
        logic [31:0] cur;
        int          n_acc;

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b0;
        #2;
        check("reset_outs", out_vec(), '0);
        check("reset_if_ready", if_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors.
        send(32'h002081B3, 32'h0000_1000);
        check("add_valid", ex_valid, 1'b1);
        check("add_alu", ex_alu_op, 4'b0000);
        check("add_rs1", ex_rs1_addr, 5'd1);
        check("add_rs2", ex_rs2_addr, 5'd2);
        check("add_rd", ex_rd_addr, 5'd3);
        check("add_we", ex_rd_we, 1'b1);
        check("add_in1", ex_in1_sel_imm, 1'b0);
        send(32'h402081B3, 32'h0000_1004);
        check("sub_alu", ex_alu_op, 4'b0001);
        send(32'h40435293, 32'h0000_1008);
        check("srai_alu", ex_alu_op, 4'b1011);
        check("srai_imm", ex_imm, 32'h0000_0004);
        check("srai_in1", ex_in1_sel_imm, 1'b1);
        send(32'hFFF00093, 32'h0000_100C);
        check("addi_imm", ex_imm, 32'hFFFF_FFFF);
        send(32'h123453B7, 32'h0000_1010);
        check("lui_imm", ex_imm, 32'h1234_5000);
        check("lui_in0", ex_in0_sel, 2'd2);
        send(32'h00000000, 32'h0000_1014);
        check("zero_illegal", ex_illegal, 1'b1);
        check("zero_we", ex_rd_we, 1'b0);
        send(32'h02208133, 32'h0000_1018);
        check("mul_illegal", ex_illegal, 1'b1);
        check("mul_we", ex_rd_we, 1'b0);
        drain();

        // Stall: ex_ready low 3 cycles with if_valid held high.
        send(32'h002081B3, 32'h0000_2000);
        snap = out_vec();
        ex_ready = 1'b0; if_valid = 1'b1; n_acc = 0;
        cur = rand_instr();
        repeat (3) begin
            if_instr = cur; if_pc = 32'h0000_2004 + 32'(n_acc * 4);
            step();
            if (s_accept) begin n_acc++; cur = rand_instr(); end
            check("stall_hold", out_vec(), snap);
        end
        check("stall_extra", n_acc, DEPTH - 1);
        check("stall_if_ready", if_ready, 1'b0);
        ex_ready = 1'b1;
        for (int i = 0; i < 4 && !s_accept; i++) begin
            if_instr = cur; if_pc = 32'h0000_2010;
            step();
        end
        check("stall_resume", s_accept, 1'b1);
        drain();

        // Flush while holding instructions (skid full in the buffered build).
        send(32'h40435293, 32'h0000_3000);
        ex_ready = 1'b0; if_valid = 1'b1;
        if_instr = rand_instr(); if_pc = 32'h0000_3004;
        step();
        step();
        flush = 1'b1; if_instr = rand_instr(); if_pc = 32'h0000_3008;
        step();
        check("flush_valid", ex_valid, 1'b0);
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        repeat (4) step();
        check("flush_no_ghost", ex_valid, 1'b0);

        // Asynchronous reset while holding instructions.
        send(32'hFFF00093, 32'h0000_4000);
        ex_ready = 1'b0; if_valid = 1'b1;
        if_instr = rand_instr(); if_pc = 32'h0000_4004;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("rst_outs", out_vec(), '0);
        check("rst_if_ready", if_ready, 1'b0);
        sb.delete();
        @(posedge clk); #1;
        check("rst_hold", ex_valid, 1'b0);
        rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        repeat (3) step();
        check("rst_no_ghost", ex_valid, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if_valid = ($urandom_range(0, 9) < 7);
            ex_ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 31) == 0);
            if_instr = rand_instr();
            if_pc    = $urandom & 32'hFFFF_FFFC;
            step();
        end
        flush = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
